// File: rtl/display_ctrl_pkg.sv
// Shared types and sizes for the UART-to-display word controller.
package display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } disp_ctrl_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

endpackage

// File: rtl/display_word_ctrl_inactivity_timer.sv
// Inter-byte inactivity timer. Counts idle cycles while a partial word is
// held and flags expiry combinationally, so the controller can abort on the
// same edge at which the count would reach TIMEOUT_CYCLES-1.
module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q;

    // Idle-cycle counter: cleared on activity or outside a partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // This idle cycle is the one that brings the count to TIMEOUT_CYCLES-1.
    assign expired = run && !clear && (cnt_q == LAST_IDLE);

endmodule

// File: rtl/display_word_ctrl.sv
// Assembles four received bytes (first byte in [31:24]) into a display word
// and commits it to the display register, with a one-deep pending buffer
// behind freeze. Optional inter-byte timeout enabled by DISP_CTRL_TIMEOUT_EN.
module display_word_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        freeze,
    output logic [31:0] disp_word,
    output logic        word_valid,
    output logic        busy,
    output logic        pending,
    output logic        timeout_err
);

    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("display_word_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    disp_ctrl_state_t  state_q, state_d;
    logic [2:0]        count_q, count_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] disp_q;
    logic [WORD_W-1:0] pbuf_q;
    logic              pend_q;
    logic              wv_q;
    logic              show;
    logic              park;
    logic              drain;

`ifdef DISP_CTRL_TIMEOUT_EN
    logic expired;
    logic abort;
    logic terr_q;

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  ((state_q != COLLECT) || rx_valid),
        .run    ((state_q == COLLECT) && !rx_valid),
        .expired(expired)
    );

    // One-cycle error pulse for each discarded partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= abort;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // State and byte-count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, byte count and commit/drain decisions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        show    = 1'b0;
        park    = 1'b0;
`ifdef DISP_CTRL_TIMEOUT_EN
        abort   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    count_d = 3'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    count_d = count_q + 3'd1;
                    if (count_q == LAST_BYTE) begin
                        state_d = COMMIT;
                    end
                end
`ifdef DISP_CTRL_TIMEOUT_EN
                else if (expired) begin
                    abort   = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
`endif
            end
            COMMIT: begin
                // The newest word always wins: shown now, or parked over any older one.
                if (freeze) begin
                    park = 1'b1;
                end else begin
                    show = 1'b1;
                end
                // A byte arriving in this cycle starts the next word.
                if (rx_valid) begin
                    count_d = 3'd1;
                    state_d = COLLECT;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
        drain = (state_q != COMMIT) && !freeze && pend_q;
    end

    // Byte shifter, display register and pending buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            disp_q  <= '0;
            pbuf_q  <= '0;
            pend_q  <= 1'b0;
            wv_q    <= 1'b0;
        end else begin
            wv_q <= 1'b0;
            if (rx_valid) begin
                shift_q <= {shift_q[WORD_W-BYTE_W-1:0], rx_data};
            end
            if (show) begin
                disp_q <= shift_q;
                wv_q   <= 1'b1;
                pend_q <= 1'b0;
            end else if (park) begin
                pbuf_q <= shift_q;
                pend_q <= 1'b1;
            end else if (drain) begin
                disp_q <= pbuf_q;
                wv_q   <= 1'b1;
                pend_q <= 1'b0;
            end
        end
    end

    assign disp_word  = disp_q;
    assign word_valid = wv_q;
    assign busy       = (state_q == COLLECT);
    assign pending    = pend_q;

endmodule

// File: tb/tb_display_word_ctrl.sv
// Bench for display_word_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a byte-queue reference model.
module tb_display_word_ctrl;

    localparam int T = 8;

`ifdef DISP_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        freeze;
    logic [31:0] disp_word;
    logic        word_valid;
    logic        busy;
    logic        pending;
    logic        timeout_err;

    always #5 clock = ~clock;

    display_word_ctrl #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .freeze     (freeze),
        .disp_word  (disp_word),
        .word_valid (word_valid),
        .busy       (busy),
        .pending    (pending),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int terr_seen = 0;

    // Reference model: bytes of the word in progress, idle count, display
    // contents and the pending word.
    logic [7:0]  mq[$];
    int          m_idle;
    logic [31:0] m_disp;
    logic [31:0] m_pbuf;
    logic        m_pend;
    logic        m_wv;
    logic        m_terr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idle = 0;
        m_disp = '0;
        m_pbuf = '0;
        m_pend = 1'b0;
        m_wv   = 1'b0;
        m_terr = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic f);
        logic [31:0] w;
        m_wv   = 1'b0;
        m_terr = 1'b0;
        if (mq.size() == 4) begin
            w = {mq[0], mq[1], mq[2], mq[3]};
            if (!f) begin
                m_disp = w;
                m_wv   = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_pbuf = w;
                m_pend = 1'b1;
            end
            mq.delete();
            m_idle = 0;
            if (v) mq.push_back(d);
        end else begin
            if (!f && m_pend) begin
                m_disp = m_pbuf;
                m_wv   = 1'b1;
                m_pend = 1'b0;
            end
            if (v) begin
                mq.push_back(d);
                m_idle = 0;
            end else if (mq.size() > 0) begin
                m_idle++;
                if (TO_EN && m_idle == T - 1) begin
                    mq.delete();
                    m_idle = 0;
                    m_terr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic b;
        b = (mq.size() >= 1) && (mq.size() <= 3);
        check_val("disp_word",   disp_word,        m_disp);
        check_val("word_valid",  32'(word_valid),  32'(m_wv));
        check_val("busy",        32'(busy),        32'(b));
        check_val("pending",     32'(pending),     32'(m_pend));
        check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic f);
        rx_valid = v;
        rx_data  = d;
        freeze   = f;
        @(posedge clock);
        model_edge(v, d, f);
        #1;
        if (timeout_err) terr_seen++;
        compare_all();
    endtask

    task automatic send_word(input logic [31:0] w, input logic f);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t[31:24], f);
            t = t << 8;
        end
    endtask

    initial begin
        logic [31:0] wtmp;
        logic        rf;
        int          gap;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        freeze   = 1'b0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check_val("rst_disp_word",   disp_word,          32'h0);
        check_val("rst_word_valid",  32'(word_valid),    32'h0);
        check_val("rst_busy",        32'(busy),          32'h0);
        check_val("rst_pending",     32'(pending),       32'h0);
        check_val("rst_timeout_err", 32'(timeout_err),   32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Word assembly.
        step(1'b1, 8'h12, 1'b0);
        check_val("asm_busy_b1", 32'(busy), 32'h1);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        check_val("asm_busy_b3", 32'(busy), 32'h1);
        step(1'b1, 8'h78, 1'b0);
        check_val("asm_no_early_wv", 32'(word_valid), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        check_val("asm_word", disp_word, 32'h12345678);
        check_val("asm_wv", 32'(word_valid), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        check_val("asm_wv_single", 32'(word_valid), 32'h0);

        // Freeze hold with pending overwrite, then release.
        send_word(32'hDEADBEEF, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        send_word(32'hCAFEF00D, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_val("frz_hold_word", disp_word, 32'h12345678);
        check_val("frz_pending", 32'(pending), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        check_val("frz_release_word", disp_word, 32'hCAFEF00D);
        check_val("frz_release_wv", 32'(word_valid), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        check_val("frz_pending_clr", 32'(pending), 32'h0);

        // Timeout on a partial word.
        terr_seen = 0;
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        repeat (12) step(1'b0, 8'h00, 1'b0);
        check_val("to_pulses", 32'(terr_seen), TO_EN ? 32'h1 : 32'h0);
        send_word(32'h01020304, 1'b0);
        step(1'b0, 8'h00, 1'b0);
`ifdef DISP_CTRL_TIMEOUT_EN
        check_val("to_next_word", disp_word, 32'h01020304);
`else
        check_val("to_held_word", disp_word, 32'hAABB0102);
`endif

        // Reset mid-word while a word is pending.
        send_word(32'h55667788, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        step(1'b1, 8'h9A, 1'b1);
        check_val("rmw_pending_before", 32'(pending), 32'h1);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("rmw_disp_word",   disp_word,        32'h0);
        check_val("rmw_busy",        32'(busy),        32'h0);
        check_val("rmw_pending",     32'(pending),     32'h0);
        check_val("rmw_word_valid",  32'(word_valid),  32'h0);
        check_val("rmw_timeout_err", 32'(timeout_err), 32'h0);
        model_reset();
        #1;
        reset = 1'b0;
        send_word(32'h9ABCDEF0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_val("rmw_clean_word", disp_word, 32'h9ABCDEF0);

        // Back-to-back bytes, one arriving in the commit cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 4) check_val("b2b_word0", disp_word, 32'h00010203);
        end
        step(1'b0, 8'h00, 1'b0);
        check_val("b2b_word1", disp_word, 32'h04050607);

        // Long idle inside a word.
        terr_seen = 0;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        repeat (10000) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_val("idle_terr_pulses", 32'(terr_seen), TO_EN ? 32'h1 : 32'h0);
`ifndef DISP_CTRL_TIMEOUT_EN
        check_val("idle_word", disp_word, 32'h11223344);
`endif

        // Randomized traffic with freeze toggling and idle gaps.
        rf  = 1'b0;
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) rf = ~rf;
            if (gap > 0) begin
                gap--;
                step(1'b0, 8'h00, rf);
            end else begin
                if ($urandom_range(0, 19) == 0) gap = $urandom_range(1, 12);
                wtmp = $urandom;
                step(($urandom_range(0, 2) != 0), wtmp[7:0], rf);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
